program_loader: RTL and testbench

Streams a program image from a byte-wide host link into the 19-bit CPU's instruction memory, then releases the core. It sits between the host/debug interface and the instruction memory write port (`we_IM`, `codein`, write address). It holds the CPU's `en` low until a complete, checksum-verified image has been written. It parses a framed byte stream, assembles 19-bit words from 3-byte groups, issues one write per word at sequential addresses, and reports DONE or ERR.

---
 rtl/program_loader.sv | 188 ++++++++++++++++++
 tb/tb_program_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
// Streams a framed program image from a byte-wide host link into the CPU's
// instruction memory and holds the core disabled until the whole image has
// been written and its checksum verified.
//
// Frame: HEADER, LEN_HI, LEN_LO, LEN x {B0,B1,B2}, CHK
//   word = {B0[2:0], B1, B2}; CHK = XOR of all bytes between HEADER and CHK.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   CLR             synchronous abort / restart to IDLE
//   IN_VALID/DATA   host byte stream; IN_READY = loader accepts this cycle
//   WR_EN/ADDR/DATA instruction memory write port (one-cycle strobe)
//   CPU_EN          high only after a verified load
//   BUSY            frame in progress
//   DONE / ERR      load verified / frame rejected (levels)
module program_loader #(
  parameter int          WORD_SIZE = 19,
  parameter int          ADDR_W    = 12,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CLR,
  input  logic                 IN_VALID,
  input  logic [7:0]           IN_DATA,
  output logic                 IN_READY,
  output logic                 WR_EN,
  output logic [ADDR_W-1:0]    WR_ADDR,
  output logic [WORD_SIZE-1:0] WR_DATA,
  output logic                 CPU_EN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERR
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LEN_HI = 4'd1;
  localparam logic [3:0] S_LEN_LO = 4'd2;
  localparam logic [3:0] S_W0     = 4'd3;
  localparam logic [3:0] S_W1     = 4'd4;
  localparam logic [3:0] S_W2     = 4'd5;
  localparam logic [3:0] S_CHK    = 4'd6;
  localparam logic [3:0] S_RUN    = 4'd7;
  localparam logic [3:0] S_ERROR  = 4'd8;

  logic [3:0]           state_q,    state_d;
  logic [ADDR_W-1:0]    addr_q,     addr_d;
  logic [11:0]          word_q,     word_d;
  logic [7:0]           acc_q,      acc_d;
  logic [3:0]           len_hi_q,   len_hi_d;
  logic [2:0]           b0_q,       b0_d;
  logic [7:0]           b1_q,       b1_d;
  logic                 in_ready_q, in_ready_d;
  logic                 wr_en_q,    wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q,  wr_addr_d;
  logic [WORD_SIZE-1:0] wr_data_q,  wr_data_d;
  logic                 cpu_en_q,   cpu_en_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;
  logic                 err_q,      err_d;

  logic accept;
  assign accept = IN_VALID && in_ready_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    acc_d     = acc_q;
    len_hi_d  = len_hi_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (CLR) begin
      // Abort wins over a byte presented in the same cycle.
      state_d = S_IDLE;
      addr_d  = '0;
      word_d  = '0;
      acc_d   = '0;
    end else if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (IN_DATA == HEADER) begin
            state_d = S_LEN_HI;
            acc_d   = '0;
            addr_d  = '0;
          end
        end
        S_LEN_HI: begin
          acc_d    = acc_q ^ IN_DATA;
          len_hi_d = IN_DATA[3:0];
          state_d  = (IN_DATA[7:4] != 4'd0) ? S_ERROR : S_LEN_LO;
        end
        S_LEN_LO: begin
          acc_d = acc_q ^ IN_DATA;
          if ({len_hi_q, IN_DATA} == 12'd0) begin
            state_d = S_CHK;
          end else begin
            word_d  = {len_hi_q, IN_DATA};
            state_d = S_W0;
          end
        end
        S_W0: begin
          // Upper B0 bits are not data but still feed the checksum.
          acc_d   = acc_q ^ IN_DATA;
          b0_d    = IN_DATA[2:0];
          state_d = S_W1;
        end
        S_W1: begin
          acc_d   = acc_q ^ IN_DATA;
          b1_d    = IN_DATA;
          state_d = S_W2;
        end
        S_W2: begin
          acc_d     = acc_q ^ IN_DATA;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = WORD_SIZE'({b0_q, b1_q, IN_DATA});
          addr_d    = addr_q + 1'b1;
          word_d    = word_q - 1'b1;
          state_d   = (word_q == 12'd1) ? S_CHK : S_W0;
        end
        S_CHK: begin
          state_d = (IN_DATA == acc_q) ? S_RUN : S_ERROR;
        end
        default: ;
      endcase
    end

    // Status outputs are registered copies of the next state so they line
    // up with the state register.
    in_ready_d = (state_d != S_RUN) && (state_d != S_ERROR);
    busy_d     = (state_d != S_IDLE) && (state_d != S_RUN) && (state_d != S_ERROR);
    done_d     = (state_d == S_RUN);
    cpu_en_d   = (state_d == S_RUN);
    err_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      acc_q      <= '0;
      len_hi_q   <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      acc_q      <= acc_d;
      len_hi_q   <= len_hi_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_en_q   <= cpu_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign IN_READY = in_ready_q;
  assign WR_EN    = wr_en_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;
  assign CPU_EN   = cpu_en_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader. Each scenario task drives a frame
// and compares observed outputs against hand-computed values.
module tb_program_loader;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CLR = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [7:0]  IN_DATA = 8'h00;
  logic        IN_READY;
  logic        WR_EN;
  logic [11:0] WR_ADDR;
  logic [18:0] WR_DATA;
  logic        CPU_EN, BUSY, DONE, ERR;

  int total = 0;
  int bad = 0;
  int ncyc = 0;
  logic [30:0] wq[$];   // {addr, data} of each observed write
  int          wc[$];   // negedge cycle index of each write

  program_loader dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR),
    .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .CPU_EN(CPU_EN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    ncyc <= ncyc + 1;
    if (RST_N && WR_EN) begin
      wq.push_back({WR_ADDR, WR_DATA});
      wc.push_back(ncyc);
    end
  end

  // Present one byte (after 'gap' idle cycles), wait for acceptance, and
  // return at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    IN_VALID = 1'b0;
    for (int i = 0; i < gap; i++) @(negedge CLK);
    IN_VALID = 1'b1;
    IN_DATA  = b;
    budget = 0;
    while (!IN_READY && budget < 20) begin
      @(negedge CLK);
      budget++;
    end
    total++;
    if (!IN_READY) begin
      bad++;
      $display("FAIL accept_timeout byte=%02h actual IN_READY=0 required 1", b);
    end
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    #12;
    total++;
    if ({IN_READY, WR_EN, WR_ADDR, WR_DATA, CPU_EN, BUSY, DONE, ERR} !== 38'd0) begin
      bad++;
      $display("FAIL reset_outputs actual=%0h required=0",
               {IN_READY, WR_EN, WR_ADDR, WR_DATA, CPU_EN, BUSY, DONE, ERR});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    total++;
    if (IN_READY !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset actual=%b required=1", IN_READY);
    end
    $display("test_reset done");
  endtask

  // Two-word frame; good=1 sends the correct checksum, else a corrupted one.
  task automatic send_two_word(input bit good);
    logic [7:0] chk;
    chk = 8'h00 ^ 8'h02 ^ 8'h05 ^ 8'h12 ^ 8'h34 ^ 8'h07 ^ 8'hFF ^ 8'hFF; // 0x26
    if (!good) chk = chk ^ 8'h01;
    wq.delete(); wc.delete();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h05, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    total++;
    if (WR_EN !== 1'b1 || WR_ADDR !== 12'd0 || WR_DATA !== 19'h51234) begin
      bad++;
      $display("FAIL write0_latency actual en=%b a=%0d d=%h required en=1 a=0 d=51234",
               WR_EN, WR_ADDR, WR_DATA);
    end
    send_byte(8'h07, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_byte(chk, 0);
    total++;
    if (wq.size() != 2 || wq[0] !== {12'd0, 19'h51234} || wq[1] !== {12'd1, 19'h7FFFF}) begin
      bad++;
      $display("FAIL two_writes actual count=%0d required 2 writes 0:51234 1:7FFFF", wq.size());
    end else begin
      total++;
      if (wc[1] - wc[0] != 3) begin
        bad++;
        $display("FAIL write_spacing actual=%0d required=3", wc[1] - wc[0]);
      end
    end
  endtask

  task automatic test_good_frame();
    send_two_word(1'b1);
    total++;
    if ({CPU_EN, DONE, ERR, BUSY, IN_READY} !== 5'b11000) begin
      bad++;
      $display("FAIL good_status actual cpu/done/err/busy/rdy=%b required 11000",
               {CPU_EN, DONE, ERR, BUSY, IN_READY});
    end
    $display("test_good_frame done writes=%0d", wq.size());
    do_clr();
  endtask

  task automatic test_bad_chk();
    send_two_word(1'b0);
    total++;
    if ({CPU_EN, DONE, ERR, BUSY, IN_READY} !== 5'b00100) begin
      bad++;
      $display("FAIL bad_chk_status actual cpu/done/err/busy/rdy=%b required 00100",
               {CPU_EN, DONE, ERR, BUSY, IN_READY});
    end
    do_clr();
    total++;
    if ({ERR, DONE, BUSY, IN_READY} !== 4'b0001) begin
      bad++;
      $display("FAIL clr_from_error actual err/done/busy/rdy=%b required 0001",
               {ERR, DONE, BUSY, IN_READY});
    end
    $display("test_bad_chk done");
  endtask

  task automatic test_len_zero();
    wq.delete(); wc.delete();
    send_byte(8'h00, 0); send_byte(8'hFF, 0);
    total++;
    if (BUSY !== 1'b0) begin
      bad++;
      $display("FAIL discard_idle actual BUSY=%b required 0", BUSY);
    end
    send_byte(8'hA5, 0);
    total++;
    if (BUSY !== 1'b1) begin
      bad++;
      $display("FAIL busy_after_header actual=%b required 1", BUSY);
    end
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    total++;
    if (DONE !== 1'b1 || CPU_EN !== 1'b1 || wq.size() != 0) begin
      bad++;
      $display("FAIL len_zero actual done=%b cpu=%b writes=%0d required 1 1 0",
               DONE, CPU_EN, wq.size());
    end
    $display("test_len_zero done");
    do_clr();
  endtask

  task automatic test_len_hi_err();
    wq.delete(); wc.delete();
    send_byte(8'hA5, 0); send_byte(8'h10, 0);
    total++;
    if (ERR !== 1'b1 || IN_READY !== 1'b0 || CPU_EN !== 1'b0 || wq.size() != 0) begin
      bad++;
      $display("FAIL len_hi_err actual err=%b rdy=%b cpu=%b writes=%0d required 1 0 0 0",
               ERR, IN_READY, CPU_EN, wq.size());
    end
    $display("test_len_hi_err done");
    do_clr();
  endtask

  task automatic test_clr_priority();
    @(negedge CLK);
    CLR = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'hA5;
    @(negedge CLK);
    CLR = 1'b0; IN_VALID = 1'b0;
    @(negedge CLK);
    total++;
    if (BUSY !== 1'b0) begin
      bad++;
      $display("FAIL clr_priority actual BUSY=%b required 0", BUSY);
    end
    $display("test_clr_priority done");
  endtask

  task automatic test_reset_midframe();
    wq.delete(); wc.delete();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    for (int w = 0; w < 2; w++) begin
      send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    end
    send_byte(8'h04, 0); send_byte(8'h05, 0);
    RST_N = 1'b0;
    #1;
    total++;
    if ({IN_READY, WR_EN, WR_ADDR, WR_DATA, CPU_EN, BUSY, DONE, ERR} !== 38'd0) begin
      bad++;
      $display("FAIL reset_midframe actual=%0h required=0",
               {IN_READY, WR_EN, WR_ADDR, WR_DATA, CPU_EN, BUSY, DONE, ERR});
    end
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    total++;
    if (wq.size() != 2) begin
      bad++;
      $display("FAIL no_partial_write actual writes=%0d required 2", wq.size());
    end
    send_two_word(1'b1);
    total++;
    if (DONE !== 1'b1) begin
      bad++;
      $display("FAIL reload_done actual=%b required 1", DONE);
    end
    $display("test_reset_midframe done");
    do_clr();
  endtask

  task automatic test_big_gaps();
    logic [7:0]  acc, b0, b1, b2;
    logic [18:0] w;
    int errs;
    wq.delete(); wc.delete();
    acc = 8'h0F ^ 8'hFF;
    send_byte(8'hA5, $urandom_range(0, 2));
    send_byte(8'h0F, $urandom_range(0, 2));
    send_byte(8'hFF, $urandom_range(0, 2));
    for (int i = 0; i < 4095; i++) begin
      w  = 19'((i * 131 + 7) * 97);
      b0 = {5'(i), w[18:16]};   // junk in upper bits must be ignored
      b1 = w[15:8];
      b2 = w[7:0];
      acc = acc ^ b0 ^ b1 ^ b2;
      send_byte(b0, $urandom_range(0, 2));
      send_byte(b1, $urandom_range(0, 2));
      send_byte(b2, $urandom_range(0, 2));
    end
    send_byte(acc, $urandom_range(0, 2));
    total++;
    if (wq.size() != 4095) begin
      bad++;
      $display("FAIL big_count actual=%0d required=4095", wq.size());
    end else begin
      errs = 0;
      for (int i = 0; i < 4095; i++) begin
        w = 19'((i * 131 + 7) * 97);
        total++;
        if (wq[i] !== {12'(i), w}) begin
          bad++;
          errs++;
          if (errs < 10)
            $display("FAIL big_word%0d actual=%h required=%h", i, wq[i], {12'(i), w});
        end
      end
    end
    total++;
    if (DONE !== 1'b1) begin
      bad++;
      $display("FAIL big_done actual=%b required 1", DONE);
    end
    $display("test_big_gaps done writes=%0d", wq.size());
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_zero();
    test_len_hi_err();
    test_clr_priority();
    test_reset_midframe();
    test_big_gaps();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
